// File: rtl/kbd_matrix_ctrl.sv
// kbd_matrix_ctrl: cached PET key matrix shared between a Pi update FIFO and CPU port-B reads.
// Optional auto-release of stuck keys when KBD_RELEASE_TIMEOUT_EN is defined.
module kbd_matrix_ctrl #(
  parameter int ROWS = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int RELEASE_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pi_wr_valid,
  output logic       pi_wr_ready,
  input  logic [3:0] pi_wr_row,
  input  logic [7:0] pi_wr_data,
  input  logic       cpu_row_wr,
  input  logic [3:0] cpu_row_data,
  input  logic       cpu_rd_req,
  input  logic       clear_req,
  output logic [7:0] kbd_data_out,
  output logic       kbd_data_valid,
  output logic       kbd_enable,
  output logic       busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(ROWS);
  localparam logic [0:0] CLEAR = 1'b0, RUN = 1'b1;
  logic [0:0] state;
  logic [SW-1:0] sweep;
  logic [3:0] row_sel;
  logic [7:0] mat [ROWS];
  logic [11:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic run, push, pop, start_clear, timeout, head_ok;
  logic [11:0] head;
  logic [7:0] rd_val;
`ifdef KBD_RELEASE_TIMEOUT_EN
  localparam int TW = $clog2(RELEASE_TIMEOUT + 1);
  logic [TW-1:0] idle;
  assign timeout = idle == TW'(RELEASE_TIMEOUT);
  always_ff @(posedge clk)
    if (reset || clear_req || push || timeout) idle <= '0;
    else if (run) idle <= idle + 1'b1;
`else
  assign timeout = RELEASE_TIMEOUT < 0;
`endif
  assign run = state == RUN;
  assign busy = state == CLEAR;
  assign start_clear = clear_req || timeout;
  assign pi_wr_ready = run && cnt != (AW+1)'(FIFO_DEPTH);
  assign push = pi_wr_valid && pi_wr_ready;
  assign pop = run && !cpu_rd_req && cnt != '0 && !start_clear;
  assign head = fifo[rp];
  assign head_ok = int'(head[11:8]) < ROWS;
  // Out-of-range rows and reads during the sweep both see a fully released row.
  assign rd_val = (run && int'(row_sel) < ROWS) ? mat[row_sel] : 8'hFF;
  always_ff @(posedge clk) begin
    if (push) fifo[wp] <= {pi_wr_row, pi_wr_data};
    if (!reset && !start_clear && state == CLEAR) mat[sweep] <= 8'hFF;
    else if (pop && head_ok) mat[head[11:8]] <= head[7:0];
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= CLEAR;
      sweep <= '0;
      row_sel <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      kbd_data_out <= 8'hFF;
      kbd_data_valid <= 1'b0;
      kbd_enable <= 1'b0;
    end else begin
      if (cpu_row_wr) row_sel <= cpu_row_data;
      kbd_data_valid <= cpu_rd_req;
      kbd_enable <= cpu_rd_req && rd_val != 8'hFF;
      if (cpu_rd_req) kbd_data_out <= rd_val;
      if (start_clear) begin
        state <= CLEAR;
        sweep <= '0;
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        if (state == CLEAR) begin
          sweep <= sweep + 1'b1;
          if (sweep == SW'(ROWS - 1)) state <= RUN;
        end
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
endmodule

// File: tb/tb_kbd_matrix_ctrl.sv
// tb_kbd_matrix_ctrl: scoreboard bench; expected read results queued at request, checked on valid.
module tb_kbd_matrix_ctrl;
  logic clk = 0, reset = 1;
  logic pi_wr_valid = 0, pi_wr_ready;
  logic [3:0] pi_wr_row = 0, cpu_row_data = 0;
  logic [7:0] pi_wr_data = 0, kbd_data_out;
  logic cpu_row_wr = 0, cpu_rd_req = 0, clear_req = 0;
  logic kbd_data_valid, kbd_enable, busy;
  int checks = 0, errors = 0;
  logic [8:0] q [$];
  logic [7:0] m [16];
  kbd_matrix_ctrl #(.ROWS(10), .FIFO_DEPTH(4), .RELEASE_TIMEOUT(100)) dut (
    .clk(clk), .reset(reset), .pi_wr_valid(pi_wr_valid), .pi_wr_ready(pi_wr_ready),
    .pi_wr_row(pi_wr_row), .pi_wr_data(pi_wr_data), .cpu_row_wr(cpu_row_wr),
    .cpu_row_data(cpu_row_data), .cpu_rd_req(cpu_rd_req), .clear_req(clear_req),
    .kbd_data_out(kbd_data_out), .kbd_data_valid(kbd_data_valid), .kbd_enable(kbd_enable),
    .busy(busy));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_rd(logic [7:0] d);
    q.push_back({d, d != 8'hFF});
  endtask
  task automatic rd(logic [3:0] row);
    cpu_row_wr = 1;
    cpu_row_data = row;
    tick();
    cpu_row_wr = 0;
    cpu_rd_req = 1;
    expect_rd(m[row]);
    tick();
    cpu_rd_req = 0;
  endtask
  task automatic pi_write(logic [3:0] row, logic [7:0] d);
    int n = 0;
    pi_wr_valid = 1;
    pi_wr_row = row;
    pi_wr_data = d;
    while (!pi_wr_ready && n < 40) begin
      tick();
      n++;
    end
    if (n == 40) check("pi_ready_timeout", 0, 1);
    tick();
    pi_wr_valid = 0;
    if (row < 10) m[row] = d;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check("busy_drop", busy, 0);
  endtask
  always @(negedge clk) begin
    if (kbd_data_valid) begin
      if (q.size() == 0) check("rd_unexpected", 1, 0);
      else check("rd_data_en", {kbd_data_out, kbd_enable}, q.pop_front());
    end else if (kbd_enable) check("en_without_valid", 1, 0);
  end
  initial begin
    int n;
    for (int i = 0; i < 16; i++) m[i] = 8'hFF;
    tick();
    reset = 0;
    check("rst_data", kbd_data_out, 8'hFF);
    check("rst_valid", kbd_data_valid, 0);
    check("rst_en", kbd_enable, 0);
    check("rst_ready", pi_wr_ready, 0);
    for (int i = 0; i < 10; i++) begin
      check("sweep_busy", busy, 1);
      tick();
    end
    check("sweep_done", busy, 0);
    check("run_ready", pi_wr_ready, 1);
    for (int r = 0; r < 10; r++) rd(4'(r));
    // row write then read
    pi_write(3, 8'hFE);
    tick();
    rd(3);
    // update and read collide: read sees old value
    pi_wr_valid = 1;
    pi_wr_row = 3;
    pi_wr_data = 8'h7F;
    cpu_rd_req = 1;
    check("collide_ready", pi_wr_ready, 1);
    expect_rd(8'hFE);
    tick();
    pi_wr_valid = 0;
    cpu_rd_req = 0;
    m[3] = 8'h7F;
    rd(3);
    // reads starve drain; FIFO fills
    cpu_rd_req = 1;
    pi_wr_valid = 1;
    for (int i = 0; i < 4; i++) begin
      pi_wr_row = 4'(5 + i);
      pi_wr_data = 8'(8'h10 * (i + 1));
      m[5 + i] = pi_wr_data;
      check("fill_ready", pi_wr_ready, 1);
      expect_rd(8'h7F);
      tick();
    end
    pi_wr_valid = 0;
    check("full_ready", pi_wr_ready, 0);
    expect_rd(8'h7F);
    tick();
    check("starved_ready", pi_wr_ready, 0);
    cpu_rd_req = 0;
    tick();
    check("pop_ready", pi_wr_ready, 1);
    repeat (3) tick();
    // row latch write coincident with read uses old row, then back-to-back reads
    cpu_row_wr = 1;
    cpu_row_data = 5;
    cpu_rd_req = 1;
    expect_rd(m[3]);
    tick();
    cpu_row_wr = 0;
    expect_rd(m[5]);
    tick();
    cpu_row_wr = 1;
    cpu_row_data = 8;
    expect_rd(m[5]);
    tick();
    cpu_row_wr = 0;
    expect_rd(m[8]);
    tick();
    cpu_rd_req = 0;
    // out-of-range row update is discarded
    pi_write(12, 8'h00);
    tick();
    rd(12);
    for (int r = 0; r < 10; r++) rd(4'(r));
    // clear sweep, read during sweep
    clear_req = 1;
    tick();
    clear_req = 0;
    check("clr_busy", busy, 1);
    check("clr_ready", pi_wr_ready, 0);
    cpu_row_data = 3;
    cpu_row_wr = 1;
    cpu_rd_req = 1;
    expect_rd(8'hFF);
    tick();
    cpu_rd_req = 0;
    cpu_row_wr = 0;
    for (int i = 0; i < 16; i++) m[i] = 8'hFF;
    wait_idle();
    rd(3);
    rd(7);
    // release timeout
    pi_write(0, 8'h00);
    tick();
    rd(0);
`ifdef KBD_RELEASE_TIMEOUT_EN
    n = 0;
    while (!busy && n < 150) begin
      tick();
      n++;
    end
    check("timeout_busy", busy, 1);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check("timeout_sweep_len", n, 10);
    m[0] = 8'hFF;
`else
    n = 0;
    repeat (120) begin
      if (busy) n++;
      tick();
    end
    check("no_timeout", n, 0);
`endif
    rd(0);
    repeat (3) tick();
    check("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
